// File: rtl/speccfa_expand.sv
// rtl/speccfa_expand.sv - CF-Log speculation marker expander
//
// Expands a compressed control-flow log into a plain src/dest entry stream.
// Plain words pass straight through the single output register. A marker word
// (upper byte == MARKER) names a block id. The block is found through a
// directory in block memory, and its header is checked against that id. The
// block entries are then streamed out one per two cycles.
//
// Optional feature macro: SPECCFA_EXPAND_REPEAT_EN
//   defined   - the word after a marker is a repeat count R (0 acts as 1), and
//               the block is emitted R times without re-reading dir/header.
//   undefined - each marker emits its block exactly once.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_data/in_ready     compressed word input handshake
//   out_valid/out_data/out_ready  expanded word output handshake
//   mem_rd/mem_addr/mem_data      block memory read port (1-cycle latency)
//   busy                  high whenever the expander is not idle
//   err                   sticky header/length error, cleared only by reset

module speccfa_expand #(
   parameter logic [15:0] DIR_BASE = 16'h0000,
   parameter logic [7:0]  MARKER   = 8'hFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   output logic        in_ready,
   output logic        out_valid,
   output logic [15:0] out_data,
   input  logic        out_ready,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   input  logic [15:0] mem_data,
   output logic        busy,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE,
`ifdef SPECCFA_EXPAND_REPEAT_EN
      CNT,
`endif
      DIR,
      DIRW,
      HDRW,
      RD,
      LOAD,
      ERR
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  id;
   logic [15:0] base;
   logic [15:0] ptr;
   logic [7:0]  remaining;
`ifdef SPECCFA_EXPAND_REPEAT_EN
   logic [7:0]  len;
   logic [15:0] rep;      // passes still to run after the current one
`endif

   logic is_marker;
   logic last_word;
   logic more_passes;

   assign is_marker = (in_data[15:8] == MARKER);
   assign last_word = (remaining == 8'd1);
   assign busy      = (state != IDLE);
   assign err       = (state == ERR);

`ifdef SPECCFA_EXPAND_REPEAT_EN
   assign more_passes = (rep != 16'd0);
`else
   assign more_passes = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      mem_rd    = 1'b0;
      mem_addr  = 16'h0000;
      case (state)
         IDLE: begin
            in_ready = !out_valid || out_ready;
            if (in_valid && in_ready && is_marker) begin
`ifdef SPECCFA_EXPAND_REPEAT_EN
               state_nxt = CNT;
`else
               state_nxt = DIR;
`endif
            end
         end
`ifdef SPECCFA_EXPAND_REPEAT_EN
         CNT: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = DIR;
         end
`endif
         DIR: begin
            mem_rd    = 1'b1;
            mem_addr  = DIR_BASE + {8'h00, id};
            state_nxt = DIRW;
         end
         DIRW: begin
            // Directory word is on mem_data now; read the header straight away.
            mem_rd    = 1'b1;
            mem_addr  = mem_data;
            state_nxt = HDRW;
         end
         HDRW: begin
            if (mem_data[15:8] != id || mem_data[7:0] == 8'd0) state_nxt = ERR;
            else                                               state_nxt = RD;
         end
         RD: begin
            // Only fetch once the output register is guaranteed free in LOAD.
            if (!out_valid || out_ready) begin
               mem_rd    = 1'b1;
               mem_addr  = ptr;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            if (!last_word || more_passes) state_nxt = RD;
            else                           state_nxt = IDLE;
         end
         ERR:     state_nxt = ERR;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_data  <= 16'h0000;
         id        <= 8'h00;
         base      <= 16'h0000;
         ptr       <= 16'h0000;
         remaining <= 8'h00;
`ifdef SPECCFA_EXPAND_REPEAT_EN
         len       <= 8'h00;
         rep       <= 16'h0000;
`endif
      end else begin
         state <= state_nxt;
         if (out_valid && out_ready) out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  if (is_marker) begin
                     id <= in_data[7:0];
`ifdef SPECCFA_EXPAND_REPEAT_EN
                     rep <= 16'h0000;
`endif
                  end else begin
                     out_data  <= in_data;
                     out_valid <= 1'b1;
                  end
               end
            end
`ifdef SPECCFA_EXPAND_REPEAT_EN
            CNT: begin
               if (in_valid) rep <= (in_data == 16'd0) ? 16'd0 : in_data - 16'd1;
            end
`endif
            DIRW: base <= mem_data;
            HDRW: begin
               ptr       <= base + 16'd1;
               remaining <= mem_data[7:0];
`ifdef SPECCFA_EXPAND_REPEAT_EN
               len       <= mem_data[7:0];
`endif
            end
            LOAD: begin
               out_data  <= mem_data;
               out_valid <= 1'b1;
               if (!last_word) begin
                  ptr       <= ptr + 16'd1;
                  remaining <= remaining - 8'd1;
               end
`ifdef SPECCFA_EXPAND_REPEAT_EN
               else if (rep != 16'd0) begin
                  ptr       <= base + 16'd1;
                  remaining <= len;
                  rep       <= rep - 16'd1;
               end
`endif
               else begin
                  ptr       <= ptr + 16'd1;
                  remaining <= remaining - 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_speccfa_expand.sv
// tb/tb_speccfa_expand.sv - self-checking bench for speccfa_expand

module tb_speccfa_expand;

   localparam logic [15:0] DIR_BASE = 16'h0000;
`ifdef SPECCFA_EXPAND_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = 16'h0000;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_ready;
   logic        fixed_ready = 1'b1;
   logic        rnd_ready = 1'b1;
   logic        rand_ready = 1'b0;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic        busy;
   logic        err;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   logic [15:0] exp_out[$];
   logic [15:0] exp_addr[$];
   logic [15:0] mem [0:65535];

   always #5 clk = ~clk;

   assign out_ready = rand_ready ? rnd_ready : fixed_ready;

   always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr] : 16'($urandom);

   always begin
      @(posedge clk);
      #1;
      if (rand_ready) rnd_ready = ($urandom_range(0, 3) != 0);
   end

   speccfa_expand #(.DIR_BASE(DIR_BASE), .MARKER(8'hFF)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .busy(busy), .err(err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && !reset) begin
         if (mem_rd) begin
            if (exp_addr.size() == 0) check("mem_rd_spurious", {16'h0, mem_addr}, 32'hFFFF_FFFF);
            else                      check("mem_addr", {16'h0, mem_addr}, {16'h0, exp_addr.pop_front()});
         end
         if (out_valid && out_ready) begin
            if (exp_out.size() == 0) check("out_spurious", {16'h0, out_data}, 32'hFFFF_FFFF);
            else                     check("out_data", {16'h0, out_data}, {16'h0, exp_out.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] w);
      int n;
      in_data  = w;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("send_accept", {31'h0, in_ready}, 32'h1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_plain(input logic [15:0] w);
      exp_out.push_back(w);
      send(w);
   endtask

   // Model: expand a marker from the memory image by the directory/header rules.
   task automatic send_marker(input logic [7:0] id, input logic [15:0] r);
      logic [15:0] b, hdr, a;
      int passes;
      b   = mem[DIR_BASE + {8'h00, id}];
      hdr = mem[b];
      exp_addr.push_back(DIR_BASE + {8'h00, id});
      exp_addr.push_back(b);
      if (hdr[15:8] == id && hdr[7:0] != 8'd0) begin
         passes = REP ? ((r == 16'd0) ? 1 : int'(r)) : 1;
         for (int p = 0; p < passes; p++) begin
            for (int i = 1; i <= int'(hdr[7:0]); i++) begin
               a = b + 16'(i);
               exp_addr.push_back(a);
               exp_out.push_back(mem[a]);
            end
         end
      end
      send({8'hFF, id});
      if (REP) send(r);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_out.size() != 0 || busy) && n < 5000) begin
         tick();
         n++;
      end
      check("drain_done", {31'h0, (n < 5000)}, 32'h1);
      check("addr_queue_empty", exp_addr.size(), 32'h0);
   endtask

   task automatic do_reset();
      mon_en   = 1'b0;
      reset    = 1'b1;
      in_valid = 1'b0;
      tick();
      tick();
      exp_out.delete();
      exp_addr.delete();
      reset  = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic setup_block(input logic [7:0] id, input logic [15:0] b, input logic [7:0] len);
      mem[b] = {id, len};
      for (int i = 1; i <= int'(len); i++) mem[b + 16'(i)] = 16'($urandom);
      mem[DIR_BASE + {8'h00, id}] = b;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      setup_block(8'd7, 16'hFFFE, 8'd2);
      setup_block(8'd1, 16'h0100, 8'($urandom_range(1, 6)));
      setup_block(8'd2, 16'h0200, 8'($urandom_range(1, 6)));
      mem[16'h0003] = 16'h0040;
      mem[16'h0040] = 16'h0302;
      mem[16'h0041] = 16'hE100;
      mem[16'h0042] = 16'hE200;

      do_reset();
      check("rst_out_valid", {31'h0, out_valid}, 32'h0);
      check("rst_out_data", {16'h0, out_data}, 32'h0);
      check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
      check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      check("rst_in_ready", {31'h0, in_ready}, 32'h1);

      // Plain pass-through, one cycle after acceptance.
      fixed_ready = 1'b1;
      send_plain(16'hE010);
      check("plain1_valid", {31'h0, out_valid}, 32'h1);
      check("plain1_data", {16'h0, out_data}, 32'h0000_E010);
      send_plain(16'hE02A);
      check("plain2_valid", {31'h0, out_valid}, 32'h1);
      check("plain2_data", {16'h0, out_data}, 32'h0000_E02A);
      drain();

      // Block 3 expansion timing.
      send_marker(8'd3, 16'd1);
      k = 1;
      while (!out_valid && k < 20) begin
         tick();
         k++;
      end
      check("first_latency", k, 32'd6);
      check("first_data", {16'h0, out_data}, 32'h0000_E100);
      tick();
      tick();
      check("second_valid", {31'h0, out_valid}, 32'h1);
      check("second_data", {16'h0, out_data}, 32'h0000_E200);
      check("busy_after_last", {31'h0, busy}, 32'h0);
      drain();

      // Output stall holds data and stops fetching.
      fixed_ready = 1'b0;
      send_marker(8'd3, 16'd1);
      k = 0;
      while (!out_valid && k < 20) begin
         tick();
         k++;
      end
      for (int c = 0; c < 10; c++) begin
         check("stall_valid", {31'h0, out_valid}, 32'h1);
         check("stall_data", {16'h0, out_data}, 32'h0000_E100);
         check("stall_mem_rd", {31'h0, mem_rd}, 32'h0);
         tick();
      end
      fixed_ready = 1'b1;
      drain();

      // Reset while in RD.
      send_marker(8'd3, 16'd1);
      k = 0;
      while (!(mem_rd && mem_addr == 16'h0041) && k < 20) begin
         tick();
         k++;
      end
      check("reached_rd", {31'h0, mem_rd}, 32'h1);
      mon_en = 1'b0;
      reset  = 1'b1;
      tick();
      check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
      check("midrst_busy", {31'h0, busy}, 32'h0);
      reset = 1'b0;
      exp_out.delete();
      exp_addr.delete();
      mon_en = 1'b1;
      send_plain(16'hE300);
      check("post_rst_data", {16'h0, out_data}, 32'h0000_E300);
      drain();

`ifdef SPECCFA_EXPAND_REPEAT_EN
      send_marker(8'd3, 16'd2);
      drain();
      send_marker(8'd1, 16'd0);
      drain();
`endif

      // Randomised mix with random back-pressure.
      rand_ready = 1'b1;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 3))
               0:       send_marker(8'd1, 16'($urandom_range(0, 3)));
               1:       send_marker(8'd2, 16'($urandom_range(0, 3)));
               2:       send_marker(8'd7, 16'($urandom_range(0, 3)));
               default: send_marker(8'd3, 16'($urandom_range(0, 3)));
            endcase
         end else begin
            send_plain({8'($urandom_range(0, 254)), 8'($urandom)});
         end
      end
      drain();
      rand_ready  = 1'b0;
      fixed_ready = 1'b1;

      // Header mismatch goes to sticky error.
      mem[16'h0040] = 16'h0502;
      send_marker(8'd3, 16'd1);
      for (int c = 0; c < 8; c++) tick();
      in_data  = 16'hE400;
      in_valid = 1'b1;
      tick();
      check("err_set", {31'h0, err}, 32'h1);
      check("err_in_ready", {31'h0, in_ready}, 32'h0);
      check("err_busy", {31'h0, busy}, 32'h1);
      check("err_mem_rd", {31'h0, mem_rd}, 32'h0);
      check("err_no_output", {31'h0, out_valid}, 32'h0);
      check("err_reads_done", exp_addr.size(), 32'h0);
      for (int c = 0; c < 5; c++) tick();
      check("err_sticky", {31'h0, err}, 32'h1);
      in_valid = 1'b0;
      mem[16'h0040] = 16'h0302;
      do_reset();
      check("err_cleared", {31'h0, err}, 32'h0);
      check("err_rst_in_ready", {31'h0, in_ready}, 32'h1);
      send_marker(8'd3, 16'd1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/speccfa_expand.md
SPECCFA_EXPAND -- requirements
Module: speccfa_expand

Interface
REQ-001 Parameter DIR_BASE, 16'h0000: word index of the block directory in block memory.
REQ-002 Parameter MARKER, 8'hFF: upper byte identifying a compressed-log speculation marker word.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  compressed CF-Log word available.
REQ-006 in_data  in  16  compressed CF-Log word.
REQ-007 in_ready  out  1  word accepted when in_valid & in_ready.
REQ-008 out_valid  out  1  expanded CF-Log word available.
REQ-009 out_data  out  16  expanded CF-Log word (src/dest entry).
REQ-010 out_ready  in  1  consumer accepts when out_valid & out_ready.
REQ-011 mem_rd  out  1  block-memory read strobe.
REQ-012 mem_addr  out  16  block-memory word index.
REQ-013 mem_data  in  16  read data, valid exactly 1 cycle after mem_rd.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 err  out  1  sticky expansion error.

Function
REQ-016 Marker word: in_data[15:8]==MARKER; in_data[7:0] is block id; any other word is a plain entry.
REQ-017 Block memory: word DIR_BASE+id holds block base B; word B holds header {id[7:0], len[7:0]}; words B+1..B+len hold len entries; all index arithmetic is 16-bit and wraps modulo 2^16.
REQ-018 Single output register; out_data/out_valid held stable while out_valid & !out_ready.
REQ-019 IDLE: in_ready = !out_valid | out_ready (combinational); a plain entry accepted in cycle T appears on out_data with out_valid high in T+1.
REQ-020 Marker accepted in IDLE: in_ready=0 until return to IDLE; the marker itself is never emitted.
REQ-021 States IDLE, CNT, DIR, DIRW, HDRW, RD, LOAD, ERR; marker -> DIR (or CNT per REQ-033); DIR: mem_rd=1, mem_addr=DIR_BASE+id; DIRW: capture base, mem_rd at base; HDRW: check header.
REQ-022 HDRW: header id != marker id, or len==0 -> ERR; otherwise remaining=len, ptr=base+1 -> RD.
REQ-023 RD: issue mem_rd at ptr only when !out_valid | out_ready, else stay in RD; -> LOAD.
REQ-024 LOAD: out_data<=mem_data, out_valid<=1, ptr+1, remaining-1; remaining!=0 -> RD, else pass complete.
REQ-025 Timing with out_ready held high and register empty: marker accepted in T -> first expanded word valid in T+6; following words every 2 cycles.
REQ-026 Pass complete with no repeats left -> IDLE; in_ready may reassert the following cycle.
REQ-027 ERR: err=1, in_ready=0, mem_rd=0; the word already in the output register still drains; remains in ERR until reset.
REQ-028 mem_rd is high only in DIR, DIRW, and the issuing cycle of RD.

Reset
REQ-029 reset in any state, including mid-expansion: next state IDLE, out_valid=0, out_data=0, mem_rd=0, mem_addr=0, err=0, busy=0, internal counters 0.
REQ-030 in_ready=1 in the first cycle after reset deasserts.
REQ-031 In-flight mem_data arriving after reset is ignored.

Configuration
REQ-032 Macro SPECCFA_EXPAND_REPEAT_EN selects repeat-count support.
REQ-033 Defined: marker -> CNT with in_ready=1; the next accepted word is repeat count R; R==0 is treated as 1; block emitted R times, with ptr reset to base+1 for each pass and no directory/header re-read.
REQ-034 Undefined: no CNT state; each marker emits exactly one pass; the word following a marker is processed normally.

Verification
REQ-035 Plain words 16'hE010, 16'hE02A with out_ready=1 -> out_data E010 then E02A, each 1 cycle after acceptance; mem_rd never asserted.
REQ-036 dir[DIR_BASE+3]=16'h0040, mem[0x40]=16'h0302, mem[0x41..0x42]=16'hE100, 16'hE200; marker 16'hFF03 -> mem_rd at 0x0003, then 0x0040, 0x0041, 0x0042; out E100, E200; first valid T+6; busy drops after the last LOAD.
REQ-037 Header 16'h0502 for marker id 3 -> err=1 and in_ready=0 permanently; reset -> err=0, in_ready=1.
REQ-038 out_ready=0 for 10 cycles during REQ-036 -> out_data holds E100 and no further mem_rd until the handshake.
REQ-039 reset asserted in RD during REQ-036 -> out_valid=0, busy=0 next cycle; a following plain word 16'hE300 passes normally.
REQ-040 SPECCFA_EXPAND_REPEAT_EN: marker FF03, count 16'h0002 -> E100, E200, E100, E200; the directory is read once.
